// File: rtl/useq_ctl.sv
// useq_ctl -- microcode sequencer for the 65C02-family cores.
// Each cycle it computes the next microcode ROM address from the current
// control word, the fetched opcode, the interrupt inputs and a branch
// condition.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high; forces addr to RESET_VEC
//   rdy        advance enable; low stalls the sequencer (addr = pc_q)
//   control    ROM word for the address issued on the last advancing cycle
//   opcode     instruction byte used at DECODE
//   cond       branch condition for BRANCH
//   irq        level-sensitive maskable interrupt requests
//   nmi        non-maskable interrupt, rising-edge sensitive
//   I          interrupt mask flag (1 = maskable irqs ignored)
//   addr       next ROM address (combinational)
//   sync       opcode decode cycle
//   we         registered write enable
//   finish     saved finisher pointer
//   irq_ack    one-hot vector-taken pulse, bit NIRQ = NMI
//   stack_err  sticky return stack under/overflow
module useq_ctl #(
  parameter int AW    = 9,
  parameter int CW    = 36,
  parameter int OP_W  = 8,
  parameter int FW    = 5,
  parameter int NIRQ  = 2,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_VEC = 'h160,
  parameter logic [AW-1:0] FIN_BASE  = 'h140,
  parameter logic [AW-1:0] IRQ_BASE  = 'h168,
  parameter logic [AW-1:0] NMI_VEC   = 'h178
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rdy,
  input  logic [CW-1:0]   control,
  input  logic [OP_W-1:0] opcode,
  input  logic            cond,
  input  logic [NIRQ-1:0] irq,
  input  logic            nmi,
  input  logic            I,
  output logic [AW-1:0]   addr,
  output logic            sync,
  output logic            we,
  output logic [FW-1:0]   finish,
  output logic [NIRQ:0]   irq_ack,
  output logic            stack_err
);

  typedef enum logic [2:0] {
    SEQ_DECODE    = 3'b000,
    SEQ_NEXT      = 3'b001,
    SEQ_FINISH    = 3'b010,
    SEQ_NEXT_SAVE = 3'b011,
    SEQ_CALL      = 3'b100,
    SEQ_RET       = 3'b101,
    SEQ_BRANCH    = 3'b110,
    SEQ_RSVD      = 3'b111
  } seq_e;

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Control word fields
  seq_e          seq;
  logic          we_nxt;
  logic [FW-1:0] fin;
  logic [AW-1:0] target;

  assign seq    = seq_e'(control[CW-1:CW-3]);
  assign we_nxt = control[CW-4];
  assign fin    = control[AW+FW-1:AW];
  assign target = control[AW-1:0];

  // Bits between the finisher field and we_nxt belong to the datapath
  // decoders, not to the sequencer.
  generate
    if (CW - 5 >= AW + FW) begin : g_spare
      logic unused_ctl;
      assign unused_ctl = ^control[CW-5:AW+FW];
    end
  endgenerate

  // State
  logic [AW-1:0]  pc_q;
  logic [AW-1:0]  stack_q [DEPTH];
  logic [SPW-1:0] sp_q;
  logic           nmi_q;
  logic           nmi_pend;

  logic [AW-1:0]  pc_inc;
  logic [SPW-1:0] sp_m1;
  logic           stk_full;
  logic           stk_empty;
  logic           adv;
  logic           is_decode;

  assign pc_inc    = pc_q + AW'(1);
  assign sp_m1     = sp_q - SPW'(1);
  assign stk_full  = (sp_q == SPW'(DEPTH));
  assign stk_empty = (sp_q == '0);
  assign adv       = rdy & ~reset;
  assign is_decode = (seq == SEQ_DECODE);

  // Interrupt arbitration: pending NMI beats any maskable channel; among
  // maskable channels the lowest index wins.
  logic          irq_hit;
  logic [AW-1:0] irq_vec;
  logic [NIRQ:0] ack_vec;

  always_comb begin
    irq_hit = 1'b0;
    irq_vec = IRQ_BASE;
    ack_vec = '0;
    if (nmi_pend) begin
      ack_vec[NIRQ] = 1'b1;
    end else if (!I) begin
      for (int unsigned k = 0; k < NIRQ; k++) begin
        if (!irq_hit && irq[k]) begin
          irq_hit    = 1'b1;
          irq_vec    = IRQ_BASE + AW'(4 * k);
          ack_vec[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    addr = pc_q;
    if (reset) begin
      addr = RESET_VEC;
    end else if (rdy) begin
      unique case (seq)
        SEQ_DECODE:    addr = nmi_pend ? NMI_VEC :
                              irq_hit  ? irq_vec : AW'(opcode);
        SEQ_FINISH:    addr = FIN_BASE + AW'(finish);
        SEQ_RET:       addr = stk_empty ? RESET_VEC : stack_q[sp_m1[IW-1:0]];
        SEQ_BRANCH:    addr = cond ? target : pc_inc;
        SEQ_NEXT, SEQ_NEXT_SAVE, SEQ_CALL, SEQ_RSVD: addr = target;
        default:       addr = target;
      endcase
    end
  end

  assign sync    = is_decode & ~reset;
  assign irq_ack = (adv && is_decode) ? ack_vec : '0;

  logic nmi_take;
  assign nmi_take = adv & is_decode & nmi_pend;

  always_ff @(posedge clk) begin
    nmi_q <= nmi;
    if (reset) begin
      pc_q      <= RESET_VEC;
      sp_q      <= '0;
      finish    <= '0;
      we        <= 1'b0;
      nmi_pend  <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      // A fresh edge in the take cycle wins over the clear.
      nmi_pend <= (nmi & ~nmi_q) | (nmi_pend & ~nmi_take);
      if (rdy) begin
        pc_q <= addr;
        we   <= we_nxt;
        unique case (seq)
          SEQ_NEXT_SAVE: finish <= fin;
          SEQ_CALL: begin
            if (stk_full) begin
              stack_q[sp_m1[IW-1:0]] <= pc_inc;
              stack_err              <= 1'b1;
            end else begin
              stack_q[sp_q[IW-1:0]] <= pc_inc;
              sp_q                  <= sp_q + SPW'(1);
            end
          end
          SEQ_RET: begin
            if (stk_empty) stack_err <= 1'b1;
            else           sp_q      <= sp_m1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_useq_ctl.sv
// Testbench for useq_ctl: directed steps from the test plan followed by a
// randomized run, all checked against a queue-based behavioural model.
module tb_useq_ctl;

  logic        clk = 1'b0;
  logic        reset, rdy, cond, nmi, I;
  logic [35:0] control;
  logic [7:0]  opcode;
  logic [1:0]  irq;
  logic [8:0]  addr;
  logic        sync, we, stack_err;
  logic [4:0]  finish;
  logic [2:0]  irq_ack;

  useq_ctl #(.AW(9), .CW(36), .OP_W(8), .FW(5), .NIRQ(2), .DEPTH(4),
             .RESET_VEC(9'h160), .FIN_BASE(9'h140), .IRQ_BASE(9'h168),
             .NMI_VEC(9'h178)) dut (
    .clk(clk), .reset(reset), .rdy(rdy), .control(control), .opcode(opcode),
    .cond(cond), .irq(irq), .nmi(nmi), .I(I), .addr(addr), .sync(sync),
    .we(we), .finish(finish), .irq_ack(irq_ack), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state
  int m_pc;
  int m_q[$];
  int m_fin;
  bit m_we, m_pend, m_nprev, m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge.
  task automatic step(input bit rst, input bit r, input int sq, input bit w,
                      input int f, input int tg, input int op, input bit c,
                      input int iq, input bit nm, input bit im, input int want);
    int ea;
    int eack;
    bit take_nmi;
    reset   = rst; rdy = r; cond = c; nmi = nm; I = im;
    irq     = 2'(iq);
    opcode  = 8'(op);
    control = {3'(sq), w, 18'h0, 5'(f), 9'(tg)};
    eack = 0;
    take_nmi = 0;
    if (rst) ea = 'h160;
    else if (!r) ea = m_pc;
    else begin
      case (sq)
        0: begin
          if (m_pend) begin ea = 'h178; eack = 4; take_nmi = 1; end
          else if (!im && iq[0]) begin ea = 'h168; eack = 1; end
          else if (!im && iq[1]) begin ea = 'h16C; eack = 2; end
          else ea = op;
        end
        2: ea = ('h140 + m_fin) % 512;
        5: ea = (m_q.size() == 0) ? 'h160 : m_q[$];
        6: ea = c ? tg : (m_pc + 1) % 512;
        default: ea = tg;
      endcase
    end
    @(negedge clk);
    chk("addr", addr, ea);
    chk("sync", sync, (sq == 0 && !rst) ? 1 : 0);
    chk("irq_ack", irq_ack, eack);
    chk("we", we, m_we);
    chk("finish", finish, m_fin);
    chk("stack_err", stack_err, m_err);
    if (want >= 0) chk("plan_addr", addr, want);
    @(posedge clk);
    if (rst) begin
      m_pc = 'h160; m_q.delete(); m_fin = 0; m_we = 0; m_pend = 0; m_err = 0;
    end else begin
      m_pend = (nm && !m_nprev) || (m_pend && !take_nmi);
      if (r) begin
        if (sq == 4) begin
          if (m_q.size() == 4) begin m_q[3] = (m_pc + 1) % 512; m_err = 1; end
          else m_q.push_back((m_pc + 1) % 512);
        end else if (sq == 5) begin
          if (m_q.size() == 0) m_err = 1;
          else void'(m_q.pop_back());
        end else if (sq == 3) m_fin = f;
        m_pc = ea;
        m_we = w;
      end
    end
    m_nprev = nm;
    #1;
  endtask

  initial begin
    // Bring-up reset without checks: DUT registers start unknown.
    reset = 1; rdy = 1; cond = 0; nmi = 0; I = 0; irq = 0; opcode = 0; control = '0;
    repeat (2) @(posedge clk);
    #1;
    m_pc = 'h160; m_fin = 0; m_we = 0; m_pend = 0; m_err = 0; m_nprev = 0;

    // Reset then release with DECODE, opcode A9
    step(1, 1, 0, 0, 0, 0, 'hA9, 0, 0, 0, 0, 'h160);
    step(0, 1, 0, 0, 0, 0, 'hA9, 0, 0, 0, 0, 'h0A9);

    // BRANCH taken / not taken / wrap
    step(0, 1, 1, 1, 0, 'h105, 0, 0, 0, 0, 0, 'h105);
    step(0, 1, 6, 0, 0, 'h120, 0, 1, 0, 0, 0, 'h120);
    step(0, 1, 1, 0, 0, 'h105, 0, 0, 0, 0, 0, 'h105);
    step(0, 1, 6, 0, 0, 'h120, 0, 0, 0, 0, 0, 'h106);
    step(0, 1, 1, 0, 0, 'h1FF, 0, 0, 0, 0, 0, 'h1FF);
    step(0, 1, 6, 1, 0, 'h120, 0, 0, 0, 0, 0, 'h000);

    // CALL x5 then RET x5 with a 4-deep stack
    step(0, 1, 1, 0, 0, 'h010, 0, 0, 0, 0, 0, 'h010);
    for (int i = 0; i < 5; i++) step(0, 1, 4, 0, 0, 'h20 + 'h10 * i, 0, 0, 0, 0, 0, 'h20 + 'h10 * i);
    step(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 'h051);
    step(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 'h031);
    step(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 'h021);
    step(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 'h011);
    step(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 'h160);
    chk("stack_err_sticky", stack_err, 1);
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 'h160);

    // Maskable interrupts at DECODE
    step(0, 1, 0, 0, 0, 0, 'h3C, 0, 3, 0, 0, 'h168);
    step(0, 1, 0, 0, 0, 0, 'h3C, 0, 3, 0, 1, 'h03C);

    // NMI pulse in a non-DECODE cycle, then two DECODEs with irq[1]
    step(0, 1, 1, 0, 0, 'h080, 0, 0, 2, 1, 0, 'h080);
    step(0, 1, 0, 0, 0, 0, 'h3C, 0, 2, 0, 0, 'h178);
    step(0, 1, 0, 0, 0, 0, 'h3C, 0, 2, 0, 0, 'h16C);

    // Stall after NEXT_SAVE, then FINISH
    step(0, 1, 3, 1, 'h07, 'h030, 0, 0, 0, 0, 0, 'h030);
    for (int i = 0; i < 3; i++) step(0, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0, 'h030);
    chk("finish_after_stall", finish, 'h07);
    step(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 'h147);

    // Randomized run
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) == 0), ($urandom_range(3) != 0),
           int'($urandom_range(7)), bit'($urandom_range(1)),
           int'($urandom_range(31)), int'($urandom_range(511)),
           int'($urandom_range(255)), bit'($urandom_range(1)),
           int'($urandom_range(3)), ($urandom_range(3) == 0),
           bit'($urandom_range(1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
